case_1_sdiv_26s_14s_26_seq: RTL and testbench
=============================================

CASE_1_SDIV_26S_14S_26_SEQ -- requirements
Module: case_1_sdiv_26s_14s_26_seq

Interface
REQ-001 Parameter ID, default 1, instance identifier only; no functional effect.
REQ-002 Parameter din0_WIDTH, default 26, signed dividend width.
REQ-003 Parameter din1_WIDTH, default 14, signed divisor and remainder width.
REQ-004 Parameter dout_WIDTH, default 26, signed quotient width; SHALL equal din0_WIDTH.
REQ-005 ap_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 ap_rst  input  1  reset, asynchronous and active-high.
REQ-007 ce  input  1  clock enable; when 0, all state, counters and outputs hold.
REQ-008 start  input  1  request a new division; sampled only when idle and ce=1.
REQ-009 din0  input  din0_WIDTH  signed dividend; captured on the accepting edge.
REQ-010 din1  input  din1_WIDTH  signed divisor; captured on the accepting edge.
REQ-011 busy  output  1  high while a division is in progress (state not IDLE).
REQ-012 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-013 dout  output  dout_WIDTH  signed quotient.
REQ-014 rem  output  din1_WIDTH  signed remainder.
REQ-015 div_by_zero  output  1  set with done when the captured divisor is 0.

Function
REQ-016 The FSM SHALL have the states IDLE, CALC and SIGN.
REQ-017 IDLE SHALL accept on start=1 and ce=1, registering |din0|, |din1|, both sign bits and a zero-divisor flag, clearing the partial remainder and iteration counter, and moving to CALC.
REQ-018 CALC SHALL perform one restoring iteration per enabled edge (shift, trial subtract, quotient bit) for exactly din0_WIDTH iterations, then move to SIGN.
REQ-019 SIGN SHALL, on one enabled edge, register dout, rem, div_by_zero and done=1, then return to IDLE.
REQ-020 done SHALL be high for exactly one enabled cycle, din0_WIDTH+1 enabled edges after the accepting edge (27 at defaults).
REQ-021 start SHALL be ignored while busy=1; no queuing, and results in flight SHALL be unaffected.
REQ-022 A start in the cycle where done=1 SHALL be accepted, giving back-to-back operation with no bubble.
REQ-023 dout, rem and div_by_zero SHALL hold their values until the next SIGN edge.
REQ-024 The quotient SHALL truncate toward zero and SHALL be negated when the operand signs differ.
REQ-025 rem SHALL take the sign of the dividend and satisfy din0 = dout*din1 + rem.
REQ-026 Magnitudes SHALL be computed one bit wider than the operands so that the most-negative operand values are exact.
REQ-027 Quotient overflow (most-negative dividend divided by -1) SHALL wrap in two's complement to the most-negative value, with rem = 0.
REQ-028 For a divisor of 0, dout SHALL be all ones, rem SHALL equal din0[din1_WIDTH-1:0], div_by_zero SHALL be 1, and latency SHALL be unchanged.
REQ-029 With ce=0, the counter SHALL not advance and done, if high, SHALL stay high until the next enabled edge.

Reset
REQ-030 ap_rst=1 SHALL immediately force state IDLE, busy=0, done=0, dout=0, rem=0, div_by_zero=0, and clear the counter and partial remainder, independent of ap_clk and ce.
REQ-031 Reset mid-operation SHALL abandon the division; no done pulse SHALL follow.
REQ-032 After ap_rst deasserts, the first enabled edge with start=1 SHALL be accepted.

Verification
REQ-033 din0=100, din1=7, start pulse -> done 27 edges later, dout=14, rem=2, div_by_zero=0.
REQ-034 Sign cases: -100/7 -> dout=-14, rem=-2; 100/-7 -> dout=-14, rem=2; -100/-7 -> dout=14, rem=-2.
REQ-035 din0=-33554432, din1=-1 -> dout=-33554432, rem=0; din0=12345, din1=-8192 -> dout=-1, rem=4153.
REQ-036 din0=500, din1=0 -> dout=0x3FFFFFF, rem=500 (low 14 bits), div_by_zero=1, done at the same latency.
REQ-037 Start 1000/3, pulse start again at edge 5 with 9/3, assert ap_rst at edge 10 -> the second start is ignored, no done follows, outputs read 0, and a fresh 9/3 yields dout=3, rem=0.
REQ-038 Hold ce=0 for 10 cycles during CALC of 100/7 -> done is delayed by exactly 10 cycles and results are unchanged; back-to-back starts on done give consecutive correct results.

Source files
------------

// File: rtl/case_1_sdiv_26s_14s_26_seq.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per enabled clock, with sign fix-up in a final state.
module case_1_sdiv_26s_14s_26_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 14,
  parameter int dout_WIDTH = 26
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int W  = din0_WIDTH;
  localparam int N  = din1_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

  state_t          state;
  logic [W-1:0]    quo;       // dividend magnitude shifts out, quotient bits shift in
  logic [N:0]      div_mag;
  logic [N:0]      part_rem;
  logic [CW-1:0]   count;
  logic            sign0;
  logic            sign1;
  logic            zero_div;
  logic [N-1:0]    din0_lo;

  // Sign-extended operands: negating one bit wider keeps the most-negative
  // values exact as magnitudes.
  logic [W:0]      ext0;
  logic [N:0]      ext1;
  logic [N+1:0]    shifted;
  logic [N+1:0]    diff;

  always_comb begin
    ext0    = {din0[W-1], din0};
    ext1    = {din1[N-1], din1};
    shifted = {part_rem, quo[W-1]};
    diff    = shifted - {1'b0, div_mag};
  end

  // NOTE: every register below is assigned with <= so all updates in one edge
  // see the pre-edge values; blocking writes here would chain the datapath.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      dout        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      quo         <= '0;
      div_mag     <= '0;
      part_rem    <= '0;
      count       <= '0;
      sign0       <= 1'b0;
      sign1       <= 1'b0;
      zero_div    <= 1'b0;
      din0_lo     <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            quo      <= W'(din0[W-1] ? -ext0 : ext0);
            div_mag  <= din1[N-1] ? -ext1 : ext1;
            sign0    <= din0[W-1];
            sign1    <= din1[N-1];
            zero_div <= (din1 == '0);
            din0_lo  <= din0[N-1:0];
            part_rem <= '0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end

        CALC: begin
          // diff's top bit is the borrow of the trial subtraction.
          quo      <= {quo[W-2:0], ~diff[N+1]};
          part_rem <= diff[N+1] ? shifted[N:0] : diff[N:0];
          count    <= count + 1'b1;
          if (count == CW'(W - 1)) state <= SIGN;
        end

        SIGN: begin
          if (zero_div) begin
            dout <= '1;
            rem  <= din0_lo;
          end else begin
            dout <= (sign0 ^ sign1) ? -quo : quo;
            rem  <= N'(sign0 ? -part_rem : part_rem);
          end
          div_by_zero <= zero_div;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_case_1_sdiv_26s_14s_26_seq.sv
// Self-checking bench for the sequential signed divider: directed corner
// cases, randomized operands against an arithmetic model, ce stalls, reset.
module tb_case_1_sdiv_26s_14s_26_seq;

  localparam int W0  = 26;
  localparam int W1  = 14;
  localparam int LAT = W0 + 1;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          ce     = 1'b1;
  logic          start  = 1'b0;
  logic [W0-1:0] din0   = '0;
  logic [W1-1:0] din1   = '0;
  logic          busy;
  logic          done;
  logic [W0-1:0] dout;
  logic [W1-1:0] rem;
  logic          div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  case_1_sdiv_26s_14s_26_seq #(
    .ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(W0)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .busy(busy), .done(done),
    .dout(dout), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference: plain signed arithmetic, truncating toward zero.
  function automatic logic [W0+W1:0] model(input logic [W0-1:0] a, input logic [W1-1:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    logic [W0-1:0] q;
    logic [W1-1:0] r;
    if (sb == 0) begin
      q = '1;
      r = a[W1-1:0];
      return {q, r, 1'b1};
    end
    q = W0'(sa / sb);
    r = W1'(sa % sb);
    return {q, r, 1'b0};
  endfunction

  // Present operands with start; returns just after the accepting edge.
  task automatic launch(input logic [W0-1:0] a, input logic [W1-1:0] b);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge ap_clk);
    #1 start = 1'b0;
  endtask

  // Count rising edges until done is seen (sampled on the falling edge).
  task automatic wait_done(output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge ap_clk);
      edges++;
      @(negedge ap_clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy, done, dout, rem, div_by_zero} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b dout=%h rem=%h dbz=%b expected all zero",
               busy, done, dout, rem, div_by_zero);
    else n_pass++;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
  endtask

  task automatic test_directed();
    logic [W0-1:0] av [7];
    logic [W1-1:0] bv [7];
    logic [W0-1:0] qv [7];
    logic [W1-1:0] rv [7];
    int   edges;
    bit   seen;
    av = '{26'd100, 26'(-100), 26'd100, 26'(-100), 26'h2000000, 26'd12345, 26'd500};
    bv = '{14'd7, 14'd7, 14'(-7), 14'(-7), 14'(-1), 14'(-8192), 14'd0};
    qv = '{26'd14, 26'(-14), 26'(-14), 26'd14, 26'h2000000, 26'(-1), 26'h3FFFFFF};
    rv = '{14'd2, 14'(-2), 14'd2, 14'(-2), 14'd0, 14'd4153, 14'd500};
    for (int i = 0; i < 7; i++) begin
      launch(av[i], bv[i]);
      wait_done(edges, seen);
      n_checks++;
      if (!seen || edges != LAT)
        $display("FAIL directed_latency[%0d]: got %0d edges (seen=%b) expected %0d", i, edges, seen, LAT);
      else n_pass++;
      n_checks++;
      if ({dout, rem, div_by_zero} !== {qv[i], rv[i], (bv[i] == '0)})
        $display("FAIL directed_result[%0d]: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                 i, dout, rem, div_by_zero, qv[i], rv[i], (bv[i] == '0));
      else n_pass++;
      @(posedge ap_clk);
      @(negedge ap_clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dout !== qv[i] || rem !== rv[i])
        $display("FAIL directed_pulse_hold[%0d]: got done=%b busy=%b q=%h r=%h expected done=0 busy=0 q=%h r=%h",
                 i, done, busy, dout, rem, qv[i], rv[i]);
      else n_pass++;
    end
  endtask

  task automatic pick(output logic [W0-1:0] a, output logic [W1-1:0] b);
    a = (($urandom_range(0, 7)) == 0) ? 26'h2000000 : W0'($urandom);
    case ($urandom_range(0, 7))
      0:       b = '0;
      1:       b = '1;
      2:       b = 14'h2000;
      3:       b = W1'($urandom_range(1, 15));
      default: b = W1'($urandom);
    endcase
  endtask

  task automatic test_random();
    logic [W0-1:0]    a;
    logic [W1-1:0]    b;
    logic [W0+W1:0]   exp_v;
    int edges;
    bit seen;
    for (int i = 0; i < 24; i++) begin
      pick(a, b);
      exp_v = model(a, b);
      launch(a, b);
      wait_done(edges, seen);
      n_checks++;
      if (!seen || edges != LAT || {dout, rem, div_by_zero} !== exp_v)
        $display("FAIL random[%0d] %h/%h: got edges=%0d q=%h r=%h z=%b expected edges=%0d q=%h r=%h z=%b",
                 i, a, b, edges, dout, rem, div_by_zero, LAT,
                 exp_v[W0+W1:W1+1], exp_v[W1:1], exp_v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_ce_hold();
    int edges;
    bit seen;
    bit held_ok = 1'b1;
    launch(26'd100, 14'd7);
    repeat (5) @(posedge ap_clk);
    @(negedge ap_clk);
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (busy !== 1'b1 || done !== 1'b0) held_ok = 1'b0;
    end
    ce = 1'b1;
    wait_done(edges, seen);
    n_checks++;
    if (!held_ok) $display("FAIL ce_hold_state: got busy/done change while ce=0 expected hold");
    else n_pass++;
    n_checks++;
    if (!seen || 5 + 10 + edges != LAT + 10 || dout !== 26'd14 || rem !== 14'd2)
      $display("FAIL ce_hold_result: got total_edges=%0d q=%h r=%h expected %0d q=%h r=%h",
               5 + 10 + edges, dout, rem, LAT + 10, 26'd14, 14'd2);
    else n_pass++;
    ce = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    n_checks++;
    if (done !== 1'b1) $display("FAIL ce_hold_done: got done=%b expected 1", done);
    else n_pass++;
    ce = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL ce_release_done: got done=%b expected 0", done);
    else n_pass++;
  endtask

  task automatic test_ignore_and_reset();
    int edges;
    bit seen;
    int extra = 0;
    // Second start while busy is ignored; the first result is unaffected.
    launch(26'd1000, 14'd3);
    repeat (4) @(posedge ap_clk);
    @(negedge ap_clk);
    launch(26'd9, 14'd3);
    wait_done(edges, seen);
    n_checks++;
    if (!seen || edges + 5 != LAT || dout !== 26'd333 || rem !== 14'd1)
      $display("FAIL ignore_start: got edges=%0d q=%h r=%h expected %0d q=%h r=%h",
               edges + 5, dout, rem, LAT, 26'd333, 14'd1);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL no_queue: got %0d busy/done cycles expected 0", extra);
    else n_pass++;

    // Reset mid-operation abandons it.
    launch(26'd1000, 14'd3);
    repeat (4) @(posedge ap_clk);
    @(negedge ap_clk);
    launch(26'd9, 14'd3);
    repeat (4) @(posedge ap_clk);
    @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, dout, rem, div_by_zero} !== '0)
      $display("FAIL reset_midop: got busy=%b done=%b q=%h r=%h z=%b expected all zero",
               busy, done, dout, rem, div_by_zero);
    else n_pass++;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL reset_no_done: got %0d busy/done cycles expected 0", extra);
    else n_pass++;
    launch(26'd9, 14'd3);
    wait_done(edges, seen);
    n_checks++;
    if (!seen || edges != LAT || dout !== 26'd3 || rem !== 14'd0 || div_by_zero !== 1'b0)
      $display("FAIL after_reset: got edges=%0d q=%h r=%h z=%b expected %0d q=%h r=%h z=0",
               edges, dout, rem, div_by_zero, LAT, 26'd3, 14'd0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W0-1:0]  a [4];
    logic [W1-1:0]  b [4];
    logic [W0+W1:0] exp_v;
    int edges;
    bit seen;
    for (int i = 0; i < 4; i++) pick(a[i], b[i]);
    @(negedge ap_clk);
    launch(a[0], b[0]);
    for (int i = 0; i < 4; i++) begin
      wait_done(edges, seen);
      exp_v = model(a[i], b[i]);
      n_checks++;
      if (!seen || edges != LAT || {dout, rem, div_by_zero} !== exp_v)
        $display("FAIL back_to_back[%0d]: got edges=%0d q=%h r=%h z=%b expected edges=%0d q=%h r=%h z=%b",
                 i, edges, dout, rem, div_by_zero, LAT,
                 exp_v[W0+W1:W1+1], exp_v[W1:1], exp_v[0]);
      else n_pass++;
      if (i < 3) launch(a[i+1], b[i+1]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ce_hold();
    test_ignore_and_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
